stall_ctrl: RTL

//   Pipeline hazard and multiply/divide scheduler for the 5-stage MIPS core.

---
 rtl/stall_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/stall_ctrl.sv
// stall_ctrl: hazard detector and HI/LO busy sequencer for the 5-stage MIPS core.
// Decides each cycle whether the D-stage instruction may issue; on a stall it
// holds PC/D and bubbles E. Also tracks the multi-cycle mult/div unit.
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        muldiv_D,
    input  logic        eret_D,
    input  logic [4:0]  wa_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  wa_M,
    input  logic [1:0]  tnew_M,
    input  logic        epc_wr_E,
    input  logic        epc_wr_M,
    input  logic        start_E,
    input  logic        is_div_E,
    output logic        stall,
    output logic        clear_E,
    output logic        busy,
    output logic [3:0]  busy_cnt,
    output logic [31:0] stall_count
);

    localparam logic [3:0] LP_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV  = 4'(DIV_CYCLES);

    logic [3:0]  r_busy_cnt;
    logic [31:0] r_stall_count;
    logic        w_start;
    logic        w_haz_rs;
    logic        w_haz_rt;
    logic        w_haz_md;
    logic        w_haz_eret;
    logic        w_stall;

    // Hazard evaluation; a register is a hazard only if a producer in E or M
    // delivers later than the consumer needs it. $zero never conflicts.
    always_comb begin
        w_start    = start_E & ~Req;
        w_haz_rs   = (rs_D != 5'd0) &
                     (((rs_D == wa_E) & (tuse_rs_D < tnew_E)) |
                      ((rs_D == wa_M) & (tuse_rs_D < tnew_M)));
        w_haz_rt   = (rt_D != 5'd0) &
                     (((rt_D == wa_E) & (tuse_rt_D < tnew_E)) |
                      ((rt_D == wa_M) & (tuse_rt_D < tnew_M)));
        busy       = w_start | (r_busy_cnt != 4'd0);
        w_haz_md   = muldiv_D & busy;
        w_haz_eret = eret_D & (epc_wr_E | epc_wr_M);
        // An exception flush overrides any stall; the pipe registers clear themselves.
        w_stall    = (w_haz_rs | w_haz_rt | w_haz_md | w_haz_eret) & ~Req;
    end

    assign stall       = w_stall;
    assign clear_E     = w_stall;
    assign busy_cnt    = r_busy_cnt;
    assign stall_count = r_stall_count;

    // HI/LO busy counter: a surviving start loads the latency, then counts to 0.
    // Req does not cancel a running operation because its commit still happens.
    always_ff @(posedge clk) begin
        if (reset)
            r_busy_cnt <= 4'd0;
        else if (w_start)
            r_busy_cnt <= is_div_E ? LP_DIV : LP_MULT;
        else if (r_busy_cnt != 4'd0)
            r_busy_cnt <= r_busy_cnt - 4'd1;
    end

    // Stalled-cycle performance counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_count <= 32'd0;
        else if (w_stall)
            r_stall_count <= r_stall_count + 32'd1;
    end

endmodule
